// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA adder controller.
// Pure declarations; no logic, no latency, no flow control.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble counter width; a single-nibble build still needs a 1-bit counter.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle between producer, adder controller and consumer.
// Valid/ready on both sides; the slave modport is the adder controller.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/cla_adder.sv
// 4-bit carry-lookahead slice: purely combinational, zero latency.
// No flow control; all carries are flattened generate/propagate terms.
module cla_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] sum_o,
  output logic       co_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & ci_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci_i);
  assign co_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci_i);

  assign sum_o = p ^ c;

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder reusing one CLA slice; result valid WIDTH/4 edges after accept.
// Accepts only in IDLE; holds result and stalls in DONE until out_ready.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_seq_adder_ctrl_if.slave  bus
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_co;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIB; n++) begin
      if (cnt_q == CW'(n)) begin
        nib_a = a_q[n*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla_adder u_slice (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .ci_i  (carry_q),
    .sum_o (nib_sum),
    .co_o  (nib_co)
  );

  // Merge the current nibble's sum into the accumulated result.
  always_comb begin
    sum_d = sum_q;
    for (int n = 0; n < NIB; n++) begin
      if (cnt_q == CW'(n)) begin
        sum_d[n*NIBBLE_W +: NIBBLE_W] = nib_sum;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ADD;
      ADD:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            sum_q   <= '0;
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= nib_co;
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ADD) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;
  assign bus.ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomised and directed checks of the nibble-serial adder against an integer-arithmetic model.
// Covers a 16-bit and a 4-bit build side by side.
module tb_cla_seq_adder_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  cla_seq_adder_ctrl_if #(.WIDTH(16)) bus16 ();
  cla_seq_adder_ctrl_if #(.WIDTH(4))  bus4 ();

  cla_seq_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  cla_seq_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic, unsigned for sum/carry, signed range test for overflow.
  task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output logic ov);
    int unsigned u;
    int          sa, sb, ss;
    u  = int'(a) + int'(b) + int'(c);
    s  = u[15:0];
    co = u[16];
    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
    sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
    ss = sa + sb + int'(c);
    ov = (ss > 32767) || (ss < -32768);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = c;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.a        = 16'($urandom);
    bus16.b        = 16'($urandom);
    bus16.cin      = 1'($urandom);
  endtask

  task automatic wait_valid16(output int edges);
    edges = 0;
    while (!bus16.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic release16();
    @(negedge clk);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic check_result16(input string tag, input logic [15:0] a,
                                input logic [15:0] b, input logic c);
    logic [15:0] s;
    logic        co, ov;
    model16(a, b, c, s, co, ov);
    check_eq({tag, ".sum"},  32'(bus16.sum),  32'(s));
    check_eq({tag, ".cout"}, 32'(bus16.cout), 32'(co));
    check_eq({tag, ".ovf"},  32'(bus16.ovf),  32'(ov));
  endtask

  task automatic run_op16(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic c);
    int edges;
    send16(a, b, c);
    wait_valid16(edges);
    check_eq({tag, ".latency"}, 32'(edges), 32'd4);
    check_result16(tag, a, b, c);
    release16();
    check_eq({tag, ".idle"}, 32'(bus16.in_ready), 32'd1);
  endtask

  initial begin
    int edges, t1, t2;
    logic [15:0] ra, rb;
    logic        rc;

    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b0;

    #1 rst_n = 1'b0;
    #12;
    check_eq("rst.in_ready",  32'(bus16.in_ready),  32'd1);
    check_eq("rst.out_valid", 32'(bus16.out_valid), 32'd0);
    check_eq("rst.busy",      32'(bus16.busy),      32'd0);
    check_eq("rst.sum",       32'(bus16.sum),       32'd0);
    check_eq("rst.cout",      32'(bus16.cout),      32'd0);
    check_eq("rst.ovf",       32'(bus16.ovf),       32'd0);
    check_eq("rst4.in_ready", 32'(bus4.in_ready),   32'd1);
    check_eq("rst4.out_valid",32'(bus4.out_valid),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op16("wrap",   16'hFFFF, 16'h0001, 1'b0);
    run_op16("posovf", 16'h7FFF, 16'h0001, 1'b0);
    run_op16("negovf", 16'h8000, 16'h8000, 1'b0);

    // Stall in DONE with a stray in_valid pulse that must be ignored.
    send16(16'h1234, 16'h4321, 1'b1);
    wait_valid16(edges);
    check_eq("hold.latency", 32'(edges), 32'd4);
    check_result16("hold", 16'h1234, 16'h4321, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus16.in_valid = 1'b1;
        bus16.a        = 16'hFFFF;
        bus16.b        = 16'hFFFF;
      end
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      check_eq("hold.out_valid", 32'(bus16.out_valid), 32'd1);
      check_eq("hold.in_ready",  32'(bus16.in_ready),  32'd0);
      check_eq("hold.sum",       32'(bus16.sum),       32'h5556);
    end
    release16();
    repeat (2) @(posedge clk);
    #1;
    check_eq("hold.no_ghost", 32'(bus16.busy), 32'd0);

    // Back-to-back with both handshakes tied high.
    @(negedge clk);
    bus16.in_valid  = 1'b1;
    bus16.a         = 16'h1234;
    bus16.b         = 16'h4321;
    bus16.cin       = 1'b1;
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.a   = 16'h0F0F;
    bus16.b   = 16'h00F1;
    bus16.cin = 1'b0;
    wait_valid16(edges);
    t1 = cyc;
    check_eq("b2b.first_lat", 32'(edges), 32'd4);
    check_eq("b2b.first_sum", 32'(bus16.sum), 32'h5556);
    edges = 0;
    while (bus16.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    wait_valid16(edges);
    t2 = cyc;
    bus16.in_valid = 1'b0;
    check_eq("b2b.spacing",    32'(t2 - t1),      32'd6);
    check_eq("b2b.second_sum", 32'(bus16.sum),    32'h1000);
    check_eq("b2b.second_co",  32'(bus16.cout),   32'd0);
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    check_eq("b2b.idle", 32'(bus16.in_ready), 32'd1);

    // Reset while the third nibble is about to be added.
    send16(16'h00AA, 16'h0055, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst.out_valid", 32'(bus16.out_valid), 32'd0);
    check_eq("midrst.sum",       32'(bus16.sum),       32'd0);
    check_eq("midrst.in_ready",  32'(bus16.in_ready),  32'd1);
    check_eq("midrst.busy",      32'(bus16.busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("midrst.no_valid", 32'(bus16.out_valid), 32'd0);
    run_op16("postrst", 16'h0001, 16'h0001, 1'b0);

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      send16(ra, rb, rc);
      wait_valid16(edges);
      check_eq("rnd.latency", 32'(edges), 32'd4);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check_result16("rnd", ra, rb, rc);
      release16();
    end

    // Single-nibble build.
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.a        = 4'hF;
    bus4.b        = 4'h1;
    bus4.cin      = 1'b0;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    edges = 0;
    while (!bus4.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_eq("w4.latency", 32'(edges),     32'd1);
    check_eq("w4.sum",     32'(bus4.sum),  32'h0);
    check_eq("w4.cout",    32'(bus4.cout), 32'd1);
    @(negedge clk);
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.out_ready = 1'b0;
    check_eq("w4.idle", 32'(bus4.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
